// File: rtl/ipv4_tx.sv
`timescale 1ns/1ps
// IPv4 transmit framer. Each transport packet gets a 20-byte, option-less IPv4
// header in front of it; the payload then passes through unchanged.
module ipv4_tx #(
    parameter int          DATA_W   = 16,
    parameter logic [31:0] SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [31:0] DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [7:0]  PROTOCOL = 8'h11,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [7:0]  DSCP_ECN = 8'h00,
    localparam int         LEN_W    = $clog2(DATA_W / 8 + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              cancel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [15:0]       pld_len_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              start_o,
    output logic              cancel_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    input  logic              ready_i,
    output logic              len_err_o
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DROP = 4'b1000
    } state_e;

    localparam logic [15:0]      MAX_PLD_LEN = 16'd65515;
    localparam logic [LEN_W-1:0] LEN_FULL    = LEN_W'(2);

    // Every header field except total length, identification and the checksum
    // itself is fixed at elaboration; only those two are added per packet.
    localparam logic [31:0] CSUM_CONST = {16'd0, 8'h45, DSCP_ECN}
                                       + 32'h0000_4000
                                       + {16'd0, TTL, PROTOCOL}
                                       + {16'd0, SRC_ADDR[31:16]}
                                       + {16'd0, SRC_ADDR[15:0]}
                                       + {16'd0, DST_ADDR[31:16]}
                                       + {16'd0, DST_ADDR[15:0]};

    function automatic logic [15:0] csum_fold(input logic [31:0] sum);
        logic [31:0] fold1;
        logic [31:0] fold2;
        fold1 = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        fold2 = {16'd0, fold1[15:0]} + {16'd0, fold1[31:16]};
        return ~fold2[15:0];
    endfunction

    state_e      state_r;
    state_e      next_state_s;
    logic [3:0]  word_idx_r;
    logic [15:0] id_cnt_r;
    logic [15:0] ident_r;
    logic [15:0] tot_len_r;
    logic [15:0] csum_r;
    logic [15:0] pld_len_r;
    logic [16:0] byte_cnt_r;
    logic        len_err_r;

    logic        start_beat_s;
    logic        len_bad_s;
    logic        last_word_s;
    logic [15:0] tot_len_s;
    logic [31:0] csum_sum_s;
    logic [16:0] byte_sum_s;
    logic        bytes_done_s;
    logic [15:0] head_word_s;

    assign start_beat_s = valid_i & start_i;
    assign len_bad_s    = (pld_len_i > MAX_PLD_LEN);
    assign last_word_s  = (word_idx_r == 4'd9);
    assign tot_len_s    = pld_len_i + 16'd20;
    assign csum_sum_s   = CSUM_CONST + {16'd0, tot_len_s} + {16'd0, id_cnt_r};
    assign byte_sum_s   = byte_cnt_r + 17'(len_i);
    assign bytes_done_s = (byte_sum_s >= {1'b0, pld_len_r});
    assign len_err_o    = len_err_r;

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_beat_s) begin
                    next_state_s = len_bad_s ? ST_DROP : ST_HEAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (cancel_i) begin
                    next_state_s = ST_IDLE;
                end else if (ready_i && last_word_s) begin
                    next_state_s = (pld_len_r == 16'd0) ? ST_IDLE : ST_DATA;
                end else begin
                    next_state_s = ST_HEAD;
                end
            end
            ST_DATA: begin
                if (cancel_i) begin
                    next_state_s = ST_IDLE;
                end else if (valid_i && ready_i && bytes_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DROP: begin
                if (cancel_i) begin
                    next_state_s = ST_IDLE;
                end else if (valid_i && bytes_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Packet context, header word index, identification and byte counters
    always_ff @(posedge clk) begin
        if (!nreset) begin
            word_idx_r <= 4'd0;
            id_cnt_r   <= 16'd0;
            ident_r    <= 16'd0;
            tot_len_r  <= 16'd0;
            csum_r     <= 16'd0;
            pld_len_r  <= 16'd0;
            byte_cnt_r <= 17'd0;
            len_err_r  <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_beat_s) begin
                        pld_len_r  <= pld_len_i;
                        byte_cnt_r <= 17'd0;
                        word_idx_r <= 4'd0;
                        if (len_bad_s) begin
                            len_err_r <= 1'b1;
                        end else begin
                            tot_len_r <= tot_len_s;
                            ident_r   <= id_cnt_r;
                            csum_r    <= csum_fold(csum_sum_s);
                        end
                    end
                end
                ST_HEAD: begin
                    if (!cancel_i && ready_i) begin
                        word_idx_r <= word_idx_r + 4'd1;
                        // Only a fully delivered header consumes an identification value.
                        if (last_word_s) begin
                            id_cnt_r <= id_cnt_r + 16'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!cancel_i && valid_i && ready_i) begin
                        byte_cnt_r <= byte_sum_s;
                    end
                end
                ST_DROP: begin
                    if (valid_i) begin
                        byte_cnt_r <= byte_sum_s;
                    end
                end
                default: begin
                    byte_cnt_r <= 17'd0;
                end
            endcase
        end
    end

    // Header field selection, fields held big-endian
    always_comb begin
        head_word_s = 16'd0;
        case (word_idx_r)
            4'd0:    head_word_s = {8'h45, DSCP_ECN};
            4'd1:    head_word_s = tot_len_r;
            4'd2:    head_word_s = ident_r;
            4'd3:    head_word_s = 16'h4000;
            4'd4:    head_word_s = {TTL, PROTOCOL};
            4'd5:    head_word_s = csum_r;
            4'd6:    head_word_s = SRC_ADDR[31:16];
            4'd7:    head_word_s = SRC_ADDR[15:0];
            4'd8:    head_word_s = DST_ADDR[31:16];
            4'd9:    head_word_s = DST_ADDR[15:0];
            default: head_word_s = 16'd0;
        endcase
    end

    // Output decode; the payload phase is a combinational pass-through
    always_comb begin
        valid_o  = 1'b0;
        ready_o  = 1'b0;
        start_o  = 1'b0;
        cancel_o = 1'b0;
        data_o   = {DATA_W{1'b0}};
        len_o    = {LEN_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                ready_o = 1'b0;
            end
            ST_HEAD: begin
                if (cancel_i) begin
                    cancel_o = 1'b1;
                end else begin
                    valid_o = 1'b1;
                    start_o = (word_idx_r == 4'd0);
                    data_o  = {head_word_s[7:0], head_word_s[15:8]};
                    len_o   = LEN_FULL;
                end
            end
            ST_DATA: begin
                if (cancel_i) begin
                    cancel_o = 1'b1;
                end else begin
                    valid_o = valid_i;
                    ready_o = ready_i;
                    data_o  = data_i;
                    len_o   = len_i;
                end
            end
            ST_DROP: begin
                ready_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule
